// File: rtl/csrbrg_pkg.sv
// csrbrg_pkg
// Shared types and constants for the Wishbone-to-CSR bridge.
//   state_t          : bridge FSM states
//   CTI_*            : Wishbone cycle-type codes the bridge understands
//   CSR_AW_DEFAULT   : default CSR word-address width
package csrbrg_pkg;

    localparam int unsigned CSR_AW_DEFAULT = 14;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        WRACK,
        RD1,
        RD2,
        RDACK
    } state_t;

endpackage

// File: rtl/csrbrg_wb.sv
// csrbrg_wb
// Wishbone classic slave to single-cycle CSR bus bridge. One transfer in
// flight at a time: writes take 2 cycles (strobe + ack together), reads take
// 4 cycles (address, peripheral read, capture + ack, return to idle).
//
// Ports
//   sys_clk, sys_rst     : clock, synchronous active-high reset
//   wb_adr_i, wb_dat_i   : byte address / write data from the interconnect
//   wb_cti_i             : cycle type, only looked at with CSRBRG_BURST_EN
//   wb_we_i, wb_cyc_i,
//   wb_stb_i             : Wishbone request qualifiers
//   wb_dat_o, wb_ack_o   : registered read data / one-cycle acknowledge
//   csr_a, csr_we, csr_do: registered CSR address, write strobe, write data
//   csr_di               : OR of peripheral read data, valid 1 cycle after csr_a
//
// Build option
//   CSRBRG_BURST_EN : when defined, incrementing write bursts are streamed at
//                     one beat per cycle while staying in WRACK.
module csrbrg_wb
    import csrbrg_pkg::*;
#(
    parameter int unsigned CSR_AW = CSR_AW_DEFAULT
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic [2:0]        wb_cti_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic              wb_ack_o,
    output logic [CSR_AW-1:0] csr_a,
    output logic              csr_we,
    output logic [31:0]       csr_do,
    input  logic [31:0]       csr_di
);

    state_t state;
    state_t state_next;

    logic request;
    logic accept;
    logic burst_beat;
    logic write_beat;
    logic capture;
    logic load;

    // Upper address bits are decoded by the interconnect, the byte lane bits
    // are meaningless on a word-only bus, and cti only matters for bursts.
    logic unused_inputs;
    assign unused_inputs = ^{wb_adr_i[31:CSR_AW+2], wb_adr_i[1:0], wb_cti_i};

    assign request = wb_cyc_i & wb_stb_i;

`ifdef CSRBRG_BURST_EN
    // Remembers whether the beat currently being acked announced that more
    // incrementing beats follow; a beat tagged END/CLASSIC clears it so the
    // burst closes after that beat's ack.
    logic burst_incr;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            burst_incr <= 1'b0;
        end else if (load) begin
            burst_incr <= (wb_cti_i == CTI_INCR);
        end
    end
`endif

    // State register; reset wins over any transfer in progress.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Requests are only looked at in IDLE, so a strobe
    // held high through the ack cycle is not taken as a second transfer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (request) begin
                    state_next = wb_we_i ? WRACK : RD1;
                end
            end
            WRACK: begin
`ifdef CSRBRG_BURST_EN
                state_next = (burst_incr && request && wb_we_i) ? WRACK : IDLE;
`else
                state_next = IDLE;
`endif
            end
            RD1:     state_next = wb_cyc_i ? RD2 : IDLE;
            RD2:     state_next = wb_cyc_i ? RDACK : IDLE;
            RDACK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: which registered outputs update on the coming edge.
    always_comb begin
        accept     = 1'b0;
        burst_beat = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: accept = request;
`ifdef CSRBRG_BURST_EN
            WRACK: burst_beat = burst_incr & request & wb_we_i;
`endif
            RD2: capture = wb_cyc_i;
            default: ;
        endcase
        load       = accept | burst_beat;
        write_beat = (accept & wb_we_i) | burst_beat;
    end

    // Registered bus outputs. csr_a/csr_do hold between transfers and
    // wb_dat_o only changes on a completed read capture.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            csr_a    <= '0;
            csr_we   <= 1'b0;
            csr_do   <= '0;
        end else begin
            csr_we   <= write_beat;
            wb_ack_o <= write_beat | capture;
            if (load) begin
                csr_a  <= wb_adr_i[CSR_AW+1:2];
                csr_do <= wb_dat_i;
            end
            if (capture) begin
                wb_dat_o <= csr_di;
            end
        end
    end

endmodule

// File: tb/tb_csrbrg_wb.sv
// tb_csrbrg_wb
// Scoreboard bench for csrbrg_wb. The driver pushes the expected ack and CSR
// write for every request; a monitor on the falling edge pops and compares
// whenever the bridge acks or strobes csr_we. A small peripheral model
// returns address-derived read data one cycle after csr_a.
module tb_csrbrg_wb;
    import csrbrg_pkg::*;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        int          cycle;
    } ack_exp_t;

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
        int          cycle;
    } wr_exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [2:0]  wb_cti_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_do;
    logic [31:0] csr_di;

    int checks = 0;
    int fails  = 0;
    int cyc_cnt = 0;

    ack_exp_t ack_q[$];
    wr_exp_t  wr_q[$];
    ack_exp_t mon_ack;
    wr_exp_t  mon_wr;

    csrbrg_wb #(.CSR_AW(14)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_cti_i (wb_cti_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_ack_o (wb_ack_o),
        .csr_a    (csr_a),
        .csr_we   (csr_we),
        .csr_do   (csr_do),
        .csr_di   (csr_di)
    );

    // 10 ns clock.
    always #5 sys_clk = ~sys_clk;

    // Cycle counter used to timestamp expected acks and strobes.
    always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

    // Peripheral model: registered read data, a fixed word at 0x008 and an
    // address-tagged pattern everywhere else.
    always @(posedge sys_clk) begin
        if (csr_a == 14'h0008) csr_di <= 32'h1234_5678;
        else                   csr_di <= {16'hA5A5, 2'b00, csr_a};
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d",
                     name, actual, expected, cyc_cnt);
        end
    endtask

    // Monitor: every ack and every csr_we pulse must match the oldest
    // outstanding expectation, including the cycle it shows up in.
    always @(negedge sys_clk) begin
        if (wb_ack_o === 1'b1) begin
            if (ack_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_ack: got 1 expected 0 at cycle %0d", cyc_cnt);
            end else begin
                mon_ack = ack_q.pop_front();
                checkOutput("ack_cycle", cyc_cnt, mon_ack.cycle);
                if (mon_ack.is_read) checkOutput("rd_data", wb_dat_o, mon_ack.data);
            end
        end
        if (csr_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_csr_we: got 1 expected 0 at cycle %0d", cyc_cnt);
            end else begin
                mon_wr = wr_q.pop_front();
                checkOutput("csr_we_cycle", cyc_cnt, mon_wr.cycle);
                checkOutput("csr_a", {18'd0, csr_a}, {18'd0, mon_wr.addr});
                checkOutput("csr_do", csr_do, mon_wr.data);
            end
        end
    end

    // Drives one request at the current falling edge and waits for its ack.
    // b2b marks a request raised in the previous ack cycle, which the bridge
    // can only accept one cycle later.
    task automatic applyStimulus(input logic we, input logic [31:0] adr,
                                 input logic [31:0] dat, input logic [31:0] exp_rd,
                                 input logic [2:0] cti, input bit b2b);
        int       lat;
        bit       seen;
        ack_exp_t ae;
        wr_exp_t  we_e;
        lat = (we ? 1 : 3) + (b2b ? 1 : 0);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_cti_i = cti;
        ae.is_read = !we;
        ae.data    = exp_rd;
        ae.cycle   = cyc_cnt + lat;
        ack_q.push_back(ae);
        if (we) begin
            we_e.addr  = adr[15:2];
            we_e.data  = dat;
            we_e.cycle = cyc_cnt + lat;
            wr_q.push_back(we_e);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge sys_clk);
            seen = (wb_ack_o === 1'b1);
        end
        if (!seen) begin
            checks++;
            fails++;
            $display("[TB] FAIL ack_timeout: got no ack expected ack for adr 0x%08h", adr);
        end
    endtask

    task automatic idleBus();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_cti_i = CTI_CLASSIC;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge sys_clk);
    endtask

    // Watchdog so a stuck run still ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sys_rst  = 1'b1;
        wb_adr_i = '0;
        wb_dat_i = '0;
        idleBus();
        waitCycles(3);
        checkOutput("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        checkOutput("rst_dat_o", wb_dat_o, 32'd0);
        checkOutput("rst_csr_a", {18'd0, csr_a}, 32'd0);
        checkOutput("rst_csr_we", {31'd0, csr_we}, 32'd0);
        checkOutput("rst_csr_do", csr_do, 32'd0);
        sys_rst = 1'b0;
        waitCycles(2);

        $display("[TB] single write");
        applyStimulus(1'b1, 32'h6000_0010, 32'hDEAD_BEEF, 32'h0, CTI_CLASSIC, 1'b0);
        idleBus();
        waitCycles(3);
        checkOutput("hold_csr_a", {18'd0, csr_a}, 32'h0000_0004);
        checkOutput("hold_csr_do", csr_do, 32'hDEAD_BEEF);
        checkOutput("idle_csr_we", {31'd0, csr_we}, 32'd0);

        $display("[TB] single read");
        applyStimulus(1'b0, 32'h6000_0020, 32'h5555_AAAA, 32'h1234_5678, CTI_CLASSIC, 1'b0);
        idleBus();
        waitCycles(3);
        checkOutput("hold_dat_o", wb_dat_o, 32'h1234_5678);

        $display("[TB] top word address");
        applyStimulus(1'b1, 32'hFFFF_FFFC, 32'h0BAD_F00D, 32'h0, CTI_CLASSIC, 1'b0);
        idleBus();
        waitCycles(2);

        $display("[TB] read then write back to back");
        applyStimulus(1'b0, 32'h6000_0010, 32'h5555_AAAA, 32'hA5A5_0004, CTI_CLASSIC, 1'b0);
        applyStimulus(1'b1, 32'h6000_0030, 32'hCAFE_F00D, 32'h0, CTI_CLASSIC, 1'b1);
        idleBus();
        waitCycles(3);

        $display("[TB] reset during read");
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 32'h6000_0014;
        wb_dat_i = 32'h5555_AAAA;
        waitCycles(2);
        sys_rst = 1'b1;
        idleBus();
        waitCycles(1);
        checkOutput("midrst_ack", {31'd0, wb_ack_o}, 32'd0);
        checkOutput("midrst_dat_o", wb_dat_o, 32'd0);
        checkOutput("midrst_csr_a", {18'd0, csr_a}, 32'd0);
        checkOutput("midrst_csr_we", {31'd0, csr_we}, 32'd0);
        checkOutput("midrst_csr_do", csr_do, 32'd0);
        sys_rst = 1'b0;
        waitCycles(4);
        applyStimulus(1'b0, 32'h6000_0030, 32'h5555_AAAA, 32'hA5A5_000C, CTI_CLASSIC, 1'b0);
        idleBus();
        waitCycles(2);

        $display("[TB] read aborted in RD1");
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 32'h6000_0008;
        waitCycles(1);
        idleBus();
        waitCycles(5);
        checkOutput("abort_dat_o", wb_dat_o, 32'hA5A5_000C);
        checkOutput("abort_csr_a", {18'd0, csr_a}, 32'h0000_0002);

`ifdef CSRBRG_BURST_EN
        $display("[TB] write burst, one beat per cycle");
        for (int b = 0; b < 4; b++) begin
            ack_exp_t ae;
            wr_exp_t  we_e;
            wb_cyc_i = 1'b1;
            wb_stb_i = 1'b1;
            wb_we_i  = 1'b1;
            wb_adr_i = 32'(b * 4);
            wb_dat_i = 32'h1111_1111 * 32'(b + 1);
            wb_cti_i = (b == 3) ? CTI_END : CTI_INCR;
            ae.is_read = 1'b0;
            ae.data    = 32'h0;
            ae.cycle   = cyc_cnt + 1;
            ack_q.push_back(ae);
            we_e.addr  = 14'(b);
            we_e.data  = 32'h1111_1111 * 32'(b + 1);
            we_e.cycle = cyc_cnt + 1;
            wr_q.push_back(we_e);
            waitCycles(1);
        end
        idleBus();
        waitCycles(3);
`else
        $display("[TB] write burst handled as classic beats");
        applyStimulus(1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0, CTI_INCR, 1'b0);
        applyStimulus(1'b1, 32'h0000_0004, 32'h2222_2222, 32'h0, CTI_INCR, 1'b1);
        applyStimulus(1'b1, 32'h0000_0008, 32'h3333_3333, 32'h0, CTI_INCR, 1'b1);
        applyStimulus(1'b1, 32'h0000_000C, 32'h4444_4444, 32'h0, CTI_END, 1'b1);
        idleBus();
        waitCycles(3);
`endif
        checkOutput("final_csr_a", {18'd0, csr_a}, 32'h0000_0003);
        checkOutput("final_csr_do", csr_do, 32'h4444_4444);

        waitCycles(3);
        checkOutput("acks_outstanding", ack_q.size(), 32'd0);
        checkOutput("writes_outstanding", wr_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
